// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble, 8-bit length (MSB first), then len payload bits pulled from bit_in.
// State register tracks the phase of the bit currently on sout; all outputs except ready are registered.
module serial_frame_tx #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PATTERN  = 4'b1101,
    parameter logic             IDLE_LVL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len_in,
    input  logic       bit_in,
    output logic       bit_req,
    output logic       sout,
    output logic       sout_valid,
    output logic       ready,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;
    logic             bit_req_q, bit_req_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       down_q, down_d;
    logic [7:0]       hdr_q, hdr_d;
    logic [PAT_W-1:0] pre_q, pre_d;
    logic [2:0]       cnt_q, cnt_d;

    always_comb begin
        state_d      = state_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        done_d       = 1'b0;
        bit_req_d    = 1'b0;
        len_d        = len_q;
        down_d       = down_q;
        hdr_d        = hdr_q;
        pre_d        = pre_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                sout_d       = IDLE_LVL;
                sout_valid_d = 1'b0;
                if (start) begin
                    state_d      = S_PREAMBLE;
                    sout_d       = PATTERN[PAT_W-1];
                    sout_valid_d = 1'b1;
                    pre_d        = PATTERN << 1;
                    cnt_d        = 3'(PAT_W - 1);
                    len_d        = len_in;
                    down_d       = len_in;
                    hdr_d        = len_in;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q != 3'd0) begin
                    sout_d = pre_q[PAT_W-1];
                    pre_d  = pre_q << 1;
                    cnt_d  = cnt_q - 3'd1;
                end else begin
                    state_d = S_HEADER;
                    sout_d  = len_q[7];
                    hdr_d   = len_q << 1;
                    cnt_d   = 3'd7;
                end
            end
            S_HEADER: begin
                if (cnt_q != 3'd0) begin
                    sout_d    = hdr_q[7];
                    hdr_d     = hdr_q << 1;
                    cnt_d     = cnt_q - 3'd1;
                    // request the first payload bit during the last header cycle
                    bit_req_d = (cnt_q == 3'd1) && (len_q != 8'd0);
                end else if (len_q != 8'd0) begin
                    state_d   = S_PAYLOAD;
                    sout_d    = bit_in;
                    down_d    = down_q - 8'd1;
                    bit_req_d = (down_q != 8'd1);
                end else begin
                    state_d      = S_DONE;
                    sout_d       = IDLE_LVL;
                    sout_valid_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            S_PAYLOAD: begin
                // down_q holds the bits still to send after the one on the line
                if (down_q != 8'd0) begin
                    sout_d    = bit_in;
                    down_d    = down_q - 8'd1;
                    bit_req_d = (down_q != 8'd1);
                end else begin
                    state_d      = S_DONE;
                    sout_d       = IDLE_LVL;
                    sout_valid_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                sout_d       = IDLE_LVL;
                sout_valid_d = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                sout_d       = IDLE_LVL;
                sout_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sout_q       <= IDLE_LVL;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            bit_req_q    <= 1'b0;
            len_q        <= 8'd0;
            down_q       <= 8'd0;
            hdr_q        <= 8'd0;
            pre_q        <= '0;
            cnt_q        <= 3'd0;
        end else begin
            state_q      <= state_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
            bit_req_q    <= bit_req_d;
            len_q        <= len_d;
            down_q       <= down_d;
            hdr_q        <= hdr_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;
    assign bit_req    = bit_req_q;
    assign ready      = (state_q == S_IDLE);

endmodule
